instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage directly upstream of the instruction decoder in the MIPS CPU. Holds the program counter and requests words from instruction memory over a req/ack handshake. Presents the fetched instruction with a valid flag to the decoder. On an advance pulse, computes the next PC from the decoder's pcSrc selection: pc+4, register-indirect, jump-absolute or branch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
TIMEOUT_CYCLES, 16, maximum cycles in REQ without imemAck before FAULT; range 1..65535.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imemAddr  output  32  word-aligned fetch address, equal to pc
imemReq  output  1  fetch request, high only in REQ
imemAck  input  1  memory response; imemData is valid in the same cycle
imemData  input  32  instruction word
instruction  output  32  latched instruction fed to the decoder
instrValid  output  1  instruction holds a valid word
pc  output  32  address of the current instruction
pcPlus4  output  32  pc+4, the link value for jal
advance  input  1  one-cycle pulse: current instruction retires, pcSrc/regRs/imm are valid
pcSrc  input  2  0 = pc+4, 1 = register indirect, 2 = jump absolute, 3 = branch
regRs  input  32  jr target, the rs register value
imm  input  16  branch offset in words
fault  output  1  sticky: misaligned target or fetch timeout
retired  output  32  count of advance pulses accepted

Behaviour:
- Reset, asynchronous, takes effect in any state:
  - pc = RESET_PC; instruction = 0; instrValid = 0; fault = 0; retired = 0; timeout counter = 0; state = REQ.
  - An imemAck arriving during or in the same cycle as reset is discarded.
- States: REQ, HOLD, FAULT.
- REQ:
  - imemReq = 1; imemAddr = pc.
  - imemAck high: latch imemData into instruction, instrValid <= 1, counter <= 0, go to HOLD. Fetch latency is therefore ack-cycle + 1.
  - No ack: counter increments. When the counter reaches TIMEOUT_CYCLES - 1 without ack, go to FAULT.
  - advance is ignored in REQ, including when it coincides with ack.
- HOLD:
  - imemReq = 0; instruction and instrValid are stable; imemAck is ignored.
  - advance high: compute nextPC, then:
    - pc <= nextPC
    - retired <= retired + 1 (wraps modulo 2^32)
    - instrValid <= 0
    - next state is REQ, or FAULT if nextPC[1:0] != 0.
- nextPC, all arithmetic 32-bit with wrap-around:
  - pcSrc 0: pc+4.
  - pcSrc 1: regRs, unmodified; misalignment is possible here.
  - pcSrc 2: {pcPlus4[31:28], instruction[25:0], 2'b00}.
  - pcSrc 3: pcPlus4 + {{14{imm[15]}}, imm, 2'b00}, with the offset sign-extended.
- FAULT:
  - fault = 1; imemReq = 0; instrValid = 0.
  - pc holds the offending or stalled address, and is updated to the bad target on a misalignment fault.
  - Only reset exits FAULT.
- pcPlus4 = pc + 4, combinational.
- A branch from pc = 32'hFFFF_FFFC wraps pcPlus4 to 0; no fault is raised.

Decomposition:
- Shared package cpu_defs:
  - pcSrc encodings: PC_PLUS4, PC_REG, PC_JUMP, PC_BRANCH.
  - fetch state encodings.
  - Reused by instructionDecoder.
- Sub-module next_pc_calc: purely combinational.
  - Inputs: pc, pcSrc, regRs, imm, instruction[25:0].
  - Outputs: nextPC, misaligned.

Test Plan:
- Reset then ack after 2 wait cycles with imemData = 32'h2008_0005 → imemReq high at addr 0 for 3 cycles; instruction = 32'h2008_0005, instrValid = 1 one cycle after ack; retired = 0.
- HOLD at pc = 0x100: advance with pcSrc = 3, imm = 16'hFFFE → pc = 0x0FC; advance with pcSrc = 0 → pc = 0x100; retired = 2.
- instruction = 32'h0800_0040 at pc = 0x1000_0000, advance with pcSrc = 2 → pc = 0x1000_0100, imemAddr = 0x1000_0100 in REQ.
- advance with pcSrc = 1, regRs = 0x202 → fault = 1, pc = 0x202, imemReq stays 0 for 20 cycles; reset → pc = RESET_PC, fault = 0.
- No ack with TIMEOUT_CYCLES = 4 → fault asserts after 4 REQ cycles; a late ack is ignored and instrValid stays 0.
- Assert reset in the same cycle as imemAck while in REQ → instruction = 0, instrValid = 0, the new fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: next-PC source select encodings, fetch FSM states and
// the branch offset helper. Also imported by the instruction decoder, so the
// pcSrc encoding lives here rather than in the fetch stage.
package cpu_defs;

   // Next-PC source, driven by the decoder alongside advance.
   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_REG    = 2'd1,
      PC_JUMP   = 2'd2,
      PC_BRANCH = 2'd3
   } pc_src_t;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_t;

   // Word offset to byte offset, sign-extended to 32 bits.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch stage bus bundle: instruction-memory req/ack side plus decoder side.
// Ports: imemAddr/imemReq/imemAck/imemData (memory), instruction/instrValid/pc/
// pcPlus4/advance/pcSrc/regRs/imm (decoder), fault/retired (status).
interface instruction_fetch_if;
   import cpu_defs::*;

   logic [31:0] imemAddr;
   logic        imemReq;
   logic        imemAck;
   logic [31:0] imemData;
   logic [31:0] instruction;
   logic        instrValid;
   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic        advance;
   pc_src_t     pcSrc;
   logic [31:0] regRs;
   logic [15:0] imm;
   logic        fault;
   logic [31:0] retired;

   // Fetch stage side.
   modport master (
      output imemAddr, imemReq, instruction, instrValid, pc, pcPlus4, fault, retired,
      input  imemAck, imemData, advance, pcSrc, regRs, imm
   );

   // Memory / decoder / environment side.
   modport slave (
      input  imemAddr, imemReq, instruction, instrValid, pc, pcPlus4, fault, retired,
      output imemAck, imemData, advance, pcSrc, regRs, imm
   );

endinterface

// File: rtl/next_pc_calc.sv
// Next program counter selection: pc+4, register indirect, jump absolute, branch.
// Latency: purely combinational.
// Ports: pc, pcSrc, regRs, imm, instrIndex (instruction[25:0]) in; nextPC, misaligned out.
module next_pc_calc
   import cpu_defs::*;
(
   input  logic [31:0] pc,
   input  pc_src_t     pcSrc,
   input  logic [31:0] regRs,
   input  logic [15:0] imm,
   input  logic [25:0] instrIndex,
   output logic [31:0] nextPC,
   output logic        misaligned
);

   logic [31:0] pc_plus4;

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      nextPC = pc_plus4;
      case (pcSrc)
         PC_PLUS4:  nextPC = pc_plus4;
         PC_REG:    nextPC = regRs;
         PC_JUMP:   nextPC = {pc_plus4[31:28], instrIndex, 2'b00};
         PC_BRANCH: nextPC = pc_plus4 + branch_offset(imm);
         default:   nextPC = pc_plus4;
      endcase
   end

   // Only a register-indirect target can actually be unaligned, but checking
   // the selected value keeps this independent of the source.
   assign misaligned = |nextPC[1:0];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds pc, fetches one word per instruction over req/ack, hands it to the decoder.
// Latency: instruction/instrValid update the cycle after imemAck; pc updates the cycle after advance.
// Backpressure: waits in HOLD until advance; a fetch with no ack for TIMEOUT_CYCLES cycles faults.
// Ports: clk, reset (async, active high), bus (instruction_fetch_if.master).
module instruction_fetch
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic                 clk,
   input logic                 reset,
   instruction_fetch_if.master bus
);

   // Last REQ wait count before giving up on the memory.
   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc_q, pc_nxt;
   logic [31:0]  instr_q, instr_nxt;
   logic [31:0]  retired_q, retired_nxt;
   logic         valid_q, valid_nxt;
   logic [15:0]  wait_q, wait_nxt;
   logic         imem_req;
   logic [31:0]  next_pc;
   logic         misaligned;

   next_pc_calc u_next_pc (
      .pc         (pc_q),
      .pcSrc      (bus.pcSrc),
      .regRs      (bus.regRs),
      .imm        (bus.imm),
      .instrIndex (instr_q[25:0]),
      .nextPC     (next_pc),
      .misaligned (misaligned)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_REQ;
         pc_q      <= RESET_PC;
         instr_q   <= 32'd0;
         valid_q   <= 1'b0;
         retired_q <= 32'd0;
         wait_q    <= 16'd0;
      end else begin
         state     <= state_nxt;
         pc_q      <= pc_nxt;
         instr_q   <= instr_nxt;
         valid_q   <= valid_nxt;
         retired_q <= retired_nxt;
         wait_q    <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc_q;
      instr_nxt   = instr_q;
      valid_nxt   = valid_q;
      retired_nxt = retired_q;
      wait_nxt    = wait_q;
      imem_req    = 1'b0;
      case (state)
         ST_REQ: begin
            // advance is deliberately not looked at here: nothing has been
            // handed to the decoder yet, so there is nothing to retire.
            imem_req = 1'b1;
            if (bus.imemAck) begin
               instr_nxt = bus.imemData;
               valid_nxt = 1'b1;
               wait_nxt  = 16'd0;
               state_nxt = ST_HOLD;
            end else if (wait_q == LAST_WAIT) begin
               state_nxt = ST_FAULT;
            end else begin
               wait_nxt = wait_q + 16'd1;
            end
         end
         ST_HOLD: begin
            if (bus.advance) begin
               pc_nxt      = next_pc;
               retired_nxt = retired_q + 32'd1;
               valid_nxt   = 1'b0;
               wait_nxt    = 16'd0;
               // pc still takes the bad target so it is visible for debug.
               state_nxt   = misaligned ? ST_FAULT : ST_REQ;
            end
         end
         ST_FAULT: begin
            valid_nxt = 1'b0;
         end
         default: begin
            state_nxt = ST_FAULT;
            valid_nxt = 1'b0;
         end
      endcase
   end

   assign bus.imemReq     = imem_req;
   assign bus.imemAddr    = pc_q;
   assign bus.pc          = pc_q;
   assign bus.pcPlus4     = pc_q + 32'd4;
   assign bus.instruction = instr_q;
   assign bus.instrValid  = valid_q;
   assign bus.retired     = retired_q;
   assign bus.fault       = (state == ST_FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a table of fetch+advance steps chained
// from reset, plus hand-written sequences for wait states, timeout, fault hold
// and reset colliding with an ack.
module tb_instruction_fetch;
   import cpu_defs::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   instruction_fetch_if bus ();

   instruction_fetch #(
      .RESET_PC       (32'h0000_0000),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  src;
      logic [31:0] rs;
      logic [15:0] imm;
      logic [31:0] data;
      logic [31:0] exp_pc;
      logic        exp_fault;
   } vec_t;

   vec_t vecs [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      bus.imemAck  = 1'b0;
      bus.advance  = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] prev_pc;
      int          req_high;

      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      bus.imemAck  = 1'b0;
      bus.imemData = 32'd0;
      bus.advance  = 1'b0;
      bus.pcSrc    = PC_PLUS4;
      bus.regRs    = 32'd0;
      bus.imm      = 16'd0;

      //            src    regRs          imm       fetched word   expected pc    fault
      vecs[0] = '{2'd1, 32'h0000_0100, 16'h0000, 32'h2008_0005, 32'h0000_0100, 1'b0};
      vecs[1] = '{2'd3, 32'h0000_0000, 16'hFFFE, 32'h1000_FFFE, 32'h0000_00FC, 1'b0};
      vecs[2] = '{2'd0, 32'h0000_0000, 16'h0000, 32'h0000_0000, 32'h0000_0100, 1'b0};
      vecs[3] = '{2'd1, 32'h1000_0000, 16'h0000, 32'h0000_0008, 32'h1000_0000, 1'b0};
      vecs[4] = '{2'd2, 32'h0000_0000, 16'h0000, 32'h0800_0040, 32'h1000_0100, 1'b0};
      vecs[5] = '{2'd1, 32'hFFFF_FFFC, 16'h0000, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0};
      vecs[6] = '{2'd3, 32'h0000_0000, 16'h0000, 32'h1000_0000, 32'h0000_0000, 1'b0};
      vecs[7] = '{2'd3, 32'h0000_0000, 16'h0010, 32'h1000_0010, 32'h0000_0044, 1'b0};
      vecs[8] = '{2'd2, 32'h0000_0000, 16'h0000, 32'h0BFF_FFFF, 32'h0FFF_FFFC, 1'b0};
      vecs[9] = '{2'd1, 32'h0000_0202, 16'h0000, 32'h0000_0000, 32'h0000_0202, 1'b1};

      // Reset state, then a fetch acked after two wait cycles; advance on the
      // ack cycle must be ignored.
      tick();
      reset = 1'b0;
      check("rst_pc", bus.pc, 32'h0);
      check("rst_instr", bus.instruction, 32'h0);
      check("rst_valid", {31'd0, bus.instrValid}, 32'd0);
      check("rst_fault", {31'd0, bus.fault}, 32'd0);
      check("rst_retired", bus.retired, 32'd0);
      for (int k = 0; k < 3; k++) begin
         check("wait_req", {31'd0, bus.imemReq}, 32'd1);
         check("wait_addr", bus.imemAddr, 32'h0);
         check("wait_valid", {31'd0, bus.instrValid}, 32'd0);
         if (k == 2) begin
            bus.imemAck  = 1'b1;
            bus.imemData = 32'h2008_0005;
            bus.advance  = 1'b1;
         end
         tick();
      end
      bus.imemAck = 1'b0;
      bus.advance = 1'b0;
      check("ack_instr", bus.instruction, 32'h2008_0005);
      check("ack_valid", {31'd0, bus.instrValid}, 32'd1);
      check("ack_req_low", {31'd0, bus.imemReq}, 32'd0);
      check("ack_retired", bus.retired, 32'd0);
      check("ack_pc", bus.pc, 32'h0);

      // Table: from REQ, ack one word, then advance with the given source.
      do_reset();
      prev_pc = 32'h0;
      for (int i = 0; i < 10; i++) begin
         check("vec_req", {31'd0, bus.imemReq}, 32'd1);
         check("vec_addr", bus.imemAddr, prev_pc);
         bus.imemAck  = 1'b1;
         bus.imemData = vecs[i].data;
         tick();
         bus.imemAck = 1'b0;
         check("vec_instr", bus.instruction, vecs[i].data);
         check("vec_valid", {31'd0, bus.instrValid}, 32'd1);
         check("vec_pcplus4", bus.pcPlus4, prev_pc + 32'd4);
         bus.advance = 1'b1;
         bus.pcSrc   = pc_src_t'(vecs[i].src);
         bus.regRs   = vecs[i].rs;
         bus.imm     = vecs[i].imm;
         tick();
         bus.advance = 1'b0;
         check("vec_pc", bus.pc, vecs[i].exp_pc);
         check("vec_fault", {31'd0, bus.fault}, {31'd0, vecs[i].exp_fault});
         check("vec_retired", bus.retired, 32'(i + 1));
         check("vec_valid_clr", {31'd0, bus.instrValid}, 32'd0);
         check("vec_req_next", {31'd0, bus.imemReq}, {31'd0, ~vecs[i].exp_fault});
         prev_pc = vecs[i].exp_pc;
      end

      // Misaligned fault is sticky: ack and advance do nothing for 20 cycles.
      req_high = 0;
      for (int k = 0; k < 20; k++) begin
         bus.imemAck  = k[0];
         bus.advance  = ~k[0];
         bus.pcSrc    = PC_PLUS4;
         bus.imemData = 32'hCAFE_0000;
         if (bus.imemReq) req_high++;
         tick();
      end
      bus.imemAck = 1'b0;
      bus.advance = 1'b0;
      check("fault_req_cycles", 32'(req_high), 32'd0);
      check("fault_pc_held", bus.pc, 32'h0000_0202);
      check("fault_sticky", {31'd0, bus.fault}, 32'd1);
      check("fault_retired", bus.retired, 32'd10);
      check("fault_valid", {31'd0, bus.instrValid}, 32'd0);
      do_reset();
      check("clr_pc", bus.pc, 32'h0);
      check("clr_fault", {31'd0, bus.fault}, 32'd0);
      check("clr_retired", bus.retired, 32'd0);
      check("clr_req", {31'd0, bus.imemReq}, 32'd1);

      // Fetch timeout after 4 REQ cycles; a late ack is ignored.
      for (int k = 0; k < 4; k++) begin
         check("tmo_req", {31'd0, bus.imemReq}, 32'd1);
         check("tmo_not_yet", {31'd0, bus.fault}, 32'd0);
         tick();
      end
      check("tmo_fault", {31'd0, bus.fault}, 32'd1);
      check("tmo_req_low", {31'd0, bus.imemReq}, 32'd0);
      check("tmo_pc", bus.pc, 32'h0);
      bus.imemAck  = 1'b1;
      bus.imemData = 32'h1234_5678;
      tick();
      tick();
      bus.imemAck = 1'b0;
      check("late_ack_valid", {31'd0, bus.instrValid}, 32'd0);
      check("late_ack_instr", bus.instruction, 32'h0);
      check("late_ack_fault", {31'd0, bus.fault}, 32'd1);

      // Reset colliding with an ack while fetching from a non-reset pc.
      do_reset();
      bus.imemAck  = 1'b1;
      bus.imemData = 32'h0000_0011;
      tick();
      bus.imemAck = 1'b0;
      bus.advance = 1'b1;
      bus.pcSrc   = PC_REG;
      bus.regRs   = 32'h0000_0040;
      tick();
      bus.advance = 1'b0;
      check("pre_rst_addr", bus.imemAddr, 32'h0000_0040);
      reset        = 1'b1;
      bus.imemAck  = 1'b1;
      bus.imemData = 32'hDEAD_BEEF;
      tick();
      reset       = 1'b0;
      bus.imemAck = 1'b0;
      check("rstack_instr", bus.instruction, 32'h0);
      check("rstack_valid", {31'd0, bus.instrValid}, 32'd0);
      check("rstack_pc", bus.pc, 32'h0);
      check("rstack_req", {31'd0, bus.imemReq}, 32'd1);
      check("rstack_addr", bus.imemAddr, 32'h0);
      tick();
      check("rstack_still_req", {31'd0, bus.imemReq}, 32'd1);
      check("rstack_still_invalid", {31'd0, bus.instrValid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
